// File: rtl/dmem_responder_pkg.sv
// Shared types for the data-memory responder: request bundle and FSM states.
package dmem_responder_pkg;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  rmask;
    logic [3:0]  wmask;
    logic [31:0] wdata;
  } dmem_req_t;

  typedef enum logic [1:0] {
    DRSP_IDLE,
    DRSP_WAIT,
    DRSP_RESP
  } dmem_rsp_state_t;

  // Wide enough for LATENCY-2 with LATENCY up to 15.
  localparam int CNT_W = 4;

endpackage

// File: rtl/dmem_byte_ram.sv
// Single-port DEPTH x 32 word array with per-byte write enables and a
// registered read. Pure storage: no control logic, contents are not reset.
module dmem_byte_ram #(
  parameter int DEPTH = 256
) (
  input  logic                     clk,
  input  logic                     en,
  input  logic [3:0]               we,
  input  logic [$clog2(DEPTH)-1:0] idx,
  input  logic [31:0]              wdata,
  output logic [31:0]              rdata
);

  logic [31:0] mem [DEPTH];

  // Byte-lane writes; a read happens only on an enabled cycle with no lanes written.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < 4; i++) begin
        if (we[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
      if (we == 4'h0) rdata <= mem[idx];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Far end of the core's dmem port: accepts one word request at a time,
// answers with a single dmem_resp pulse LATENCY cycles later.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int LATENCY = 2,
  parameter int DEPTH   = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] dmem_addr,
  input  logic [3:0]  dmem_rmask,
  input  logic [3:0]  dmem_wmask,
  input  logic [31:0] dmem_wdata,
  output logic [31:0] dmem_rdata,
  output logic        dmem_resp,
  output logic        dmem_busy,
  output logic        dmem_err
);

  localparam int AW = $clog2(DEPTH);

  dmem_rsp_state_t  state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  dmem_req_t        in_req, held, op;
  logic             req_vld, req_bad, accept, err_set, ram_en;
  logic [31:0]      ram_rdata;
  logic             unused_op;

  // Bundle the live port fields.
  always_comb begin
    in_req = '{addr: dmem_addr, rmask: dmem_rmask, wmask: dmem_wmask, wdata: dmem_wdata};
  end

  // Next state, latency countdown, acceptance and protocol-error detection.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    err_set   = 1'b0;
    req_vld   = (|dmem_rmask) | (|dmem_wmask);
    req_bad   = (|dmem_rmask) & (|dmem_wmask);
    case (state)
      DRSP_WAIT: begin
        if (req_vld) err_set = 1'b1;
        if (cnt == '0) state_nxt = DRSP_RESP;
        else           cnt_nxt   = cnt - 1'b1;
      end
      default: begin
        // IDLE and RESP both accept; RESP falls back to IDLE when nothing new arrives.
        state_nxt = DRSP_IDLE;
        if (req_vld) begin
          if (req_bad) begin
            err_set = 1'b1;
          end else begin
            accept = 1'b1;
            if (LATENCY == 1) begin
              state_nxt = DRSP_RESP;
            end else begin
              state_nxt = DRSP_WAIT;
              cnt_nxt   = CNT_W'(LATENCY - 2);
            end
          end
        end
      end
    endcase
  end

  // The array access happens on the edge entering RESP. With LATENCY=1 that
  // edge is the accept edge, so the live request drives the array directly.
  // Reset suppresses the access so a dropped write never commits.
  always_comb begin
    op     = (state == DRSP_WAIT) ? held : in_req;
    ram_en = (state_nxt == DRSP_RESP) && !rst;
  end

  assign unused_op = ^{op.addr, op.rmask};

  // State, counter, sticky error and held request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= DRSP_IDLE;
      cnt      <= '0;
      dmem_err <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (err_set) dmem_err <= 1'b1;
      if (accept)  held     <= in_req;
    end
  end

  dmem_byte_ram #(.DEPTH(DEPTH)) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (op.wmask),
    .idx   (op.addr[2 +: AW]),
    .wdata (op.wdata),
    .rdata (ram_rdata)
  );

  // Read data is only driven during a read's RESP cycle; zero otherwise.
  always_comb begin
    dmem_resp  = (state == DRSP_RESP);
    dmem_busy  = (state == DRSP_WAIT);
    dmem_rdata = (dmem_resp && held.wmask == 4'h0) ? ram_rdata : 32'h0;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized + directed bench for dmem_responder at LATENCY=2 and LATENCY=1.
module tb_dmem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_i   [2];
  logic [31:0] addr_i  [2];
  logic [3:0]  rm_i    [2];
  logic [3:0]  wm_i    [2];
  logic [31:0] wdata_i [2];
  logic [31:0] rdata_o [2];
  logic        resp_o  [2];
  logic        busy_o  [2];
  logic        err_o   [2];

  dmem_responder #(.LATENCY(2), .DEPTH(256)) u_l2 (
    .clk(clk), .rst(rst_i[0]), .dmem_addr(addr_i[0]), .dmem_rmask(rm_i[0]),
    .dmem_wmask(wm_i[0]), .dmem_wdata(wdata_i[0]), .dmem_rdata(rdata_o[0]),
    .dmem_resp(resp_o[0]), .dmem_busy(busy_o[0]), .dmem_err(err_o[0]));

  dmem_responder #(.LATENCY(1), .DEPTH(256)) u_l1 (
    .clk(clk), .rst(rst_i[1]), .dmem_addr(addr_i[1]), .dmem_rmask(rm_i[1]),
    .dmem_wmask(wm_i[1]), .dmem_wdata(wdata_i[1]), .dmem_rdata(rdata_o[1]),
    .dmem_resp(resp_o[1]), .dmem_busy(busy_o[1]), .dmem_err(err_o[1]));

  int errs = 0, checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: one outstanding transaction with an absolute due cycle.
  int          cyc = 0;
  bit          chk_en = 0;
  bit          pend [2];
  int          due  [2];
  int          pidx [2];
  logic [3:0]  pwm  [2];
  logic [31:0] pwd  [2];
  bit          merr [2];
  logic [31:0] mm   [2][256];
  logic [31:0] last_rd [2];

  function automatic int lat_of(input int d);
    return (d == 0) ? 2 : 1;
  endfunction

  function automatic bit waiting(input int d);
    return pend[d] && (cyc < due[d]);
  endfunction

  task automatic step(input int d, input bit r, input logic [3:0] rm, input logic [3:0] wm,
                      input logic [31:0] a, input logic [31:0] wd);
    bit          e_resp, e_busy;
    logic [31:0] e_rd;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      rst_i[k] = 1'b0; rm_i[k] = 4'h0; wm_i[k] = 4'h0;
      addr_i[k] = $urandom; wdata_i[k] = $urandom;
    end
    rst_i[d] = r; rm_i[d] = rm; wm_i[d] = wm; addr_i[d] = a; wdata_i[d] = wd;
    e_resp = pend[d] && (cyc == due[d]);
    e_busy = waiting(d);
    e_rd   = 32'h0;
    if (e_resp) begin
      if (pwm[d] != 4'h0) begin
        for (int i = 0; i < 4; i++)
          if (pwm[d][i]) mm[d][pidx[d]][8*i +: 8] = pwd[d][8*i +: 8];
      end else begin
        e_rd = mm[d][pidx[d]];
      end
    end
    if (chk_en) begin
      check($sformatf("resp d%0d c%0d", d, cyc), resp_o[d], e_resp);
      check($sformatf("busy d%0d c%0d", d, cyc), busy_o[d], e_busy);
      check($sformatf("rdata d%0d c%0d", d, cyc), rdata_o[d], e_rd);
      check($sformatf("err d%0d c%0d", d, cyc), err_o[d], merr[d]);
    end
    if (resp_o[d] === 1'b1) last_rd[d] = rdata_o[d];
    if (e_resp) pend[d] = 0;
    if (r) begin
      pend[d] = 0;
      merr[d] = 0;
    end else if (rm != 4'h0 || wm != 4'h0) begin
      if (pend[d] || (rm != 4'h0 && wm != 4'h0)) begin
        merr[d] = 1;
      end else begin
        pend[d] = 1;
        due[d]  = cyc + lat_of(d);
        pidx[d] = int'(a[9:2]);
        pwm[d]  = wm;
        pwd[d]  = wd;
      end
    end
    cyc++;
  endtask

  task automatic idle(input int d);
    step(d, 1'b0, 4'h0, 4'h0, 32'h0, 32'h0);
  endtask

  task automatic issue(input int d, input logic [3:0] rm, input logic [3:0] wm,
                       input logic [31:0] a, input logic [31:0] wd);
    int n = 0;
    while (waiting(d) && n < 20) begin idle(d); n++; end
    if (n >= 20) check("issue_timeout", 32'd1, 32'd0);
    step(d, 1'b0, rm, wm, a, wd);
  endtask

  task automatic drain(input int d);
    int n = 0;
    while (pend[d] && n < 20) begin idle(d); n++; end
    if (pend[d]) check("drain_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    logic [31:0] prior, v;
    for (int k = 0; k < 2; k++) begin
      rst_i[k] = 1'b1; rm_i[k] = 4'h0; wm_i[k] = 4'h0; addr_i[k] = 32'h0; wdata_i[k] = 32'h0;
      pend[k] = 0; merr[k] = 0; last_rd[k] = 32'h0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      rst_i[k] = 1'b0;
      check("rst_resp", resp_o[k], 32'h0);
      check("rst_busy", busy_o[k], 32'h0);
      check("rst_rdata", rdata_o[k], 32'h0);
      check("rst_err", err_o[k], 32'h0);
    end
    chk_en = 1;

    // Give every word a known value.
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 256; i++) issue(d, 4'h0, 4'hF, 32'(i) << 2, $urandom);
      drain(d);
    end

    // LATENCY=2: write then read, byte-lane merge, back-to-back reads.
    issue(0, 4'h0, 4'hF, 32'h40, 32'hDEADBEEF);
    issue(0, 4'hF, 4'h0, 32'h40, 32'h0);
    drain(0);
    check("wr_rd", last_rd[0], 32'hDEADBEEF);
    issue(0, 4'h0, 4'b0010, 32'h41, 32'h0000AA00);
    issue(0, 4'h1, 4'h0, 32'h40, 32'h0);
    drain(0);
    check("byte_mask", last_rd[0], 32'hDEADAAEF);
    issue(0, 4'h0, 4'hF, 32'h44, 32'h0BADF00D);
    issue(0, 4'hF, 4'h0, 32'h40, 32'h0);
    issue(0, 4'hF, 4'h0, 32'h44, 32'h0);
    drain(0);
    check("b2b_second", last_rd[0], 32'h0BADF00D);
    check("b2b_no_err", err_o[0], 32'h0);

    // Request during WAIT is ignored and latches the sticky error.
    issue(0, 4'h0, 4'hF, 32'h50, 32'h11112222);
    step(0, 1'b0, 4'hF, 4'h0, 32'h54, 32'h0);
    drain(0);
    idle(0); idle(0);
    check("err_sticky", err_o[0], 32'h1);
    step(0, 1'b1, 4'h0, 4'h0, 32'h0, 32'h0);
    idle(0);
    // Read and write masks together is also a protocol error.
    step(0, 1'b0, 4'h1, 4'h1, 32'h60, 32'h0);
    idle(0);
    check("err_both_masks", err_o[0], 32'h1);
    step(0, 1'b1, 4'h0, 4'h0, 32'h0, 32'h0);

    // Reset mid-flight drops the write.
    prior = mm[0][32];
    issue(0, 4'h0, 4'hF, 32'h80, 32'h12345678);
    step(0, 1'b1, 4'h0, 4'h0, 32'h0, 32'h0);
    idle(0); idle(0);
    issue(0, 4'hF, 4'h0, 32'h80, 32'h0);
    drain(0);
    check("rst_drop", last_rd[0], prior);

    // LATENCY=1 with address wrap.
    issue(1, 4'h0, 4'hF, 32'h400, 32'h55);
    issue(1, 4'hF, 4'h0, 32'h000, 32'h0);
    drain(1);
    check("wrap_l1", last_rd[1], 32'h55);

    // Randomized traffic on both instances.
    for (int d = 0; d < 2; d++) begin
      step(d, 1'b1, 4'h0, 4'h0, 32'h0, 32'h0);
      for (int n = 0; n < 400; n++) begin
        int sel;
        sel = int'($urandom_range(0, 99));
        if (sel == 0) begin
          step(d, 1'b1, 4'h0, 4'h0, 32'h0, 32'h0);
        end else if (!waiting(d) && sel < 75) begin
          v = $urandom;
          case ($urandom_range(0, 19))
            0:       step(d, 1'b0, 4'(  $urandom_range(1, 15)), 4'($urandom_range(1, 15)), $urandom, v);
            1,2,3,4,5,6,7,8,9:
                     step(d, 1'b0, 4'h0, 4'($urandom_range(1, 15)), $urandom, v);
            default: step(d, 1'b0, 4'($urandom_range(1, 15)), 4'h0, $urandom, v);
          endcase
        end else if (waiting(d) && sel < 3) begin
          step(d, 1'b0, 4'hF, 4'h0, $urandom, 32'h0);
        end else begin
          idle(d);
        end
      end
      drain(d);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
